manual_drive_seq: RTL and testbench

Registered, parametrised successor to the combinational manual-mode next-state logic of the car controller. Owns power sequencing (hold-to-toggle power button), the NSTART/START/MOVING drive FSM with a latched gear direction, blinking turn signals, and a saturating odometer. It sits between the debounced switch inputs and the LED/7-seg display layer. All outputs are registered, so the display layer sees glitch-free state.

---
 rtl/car_pkg.sv | 41 ++++
 rtl/manual_drive_seq_if.sv | 40 ++++
 rtl/manual_drive_seq_btn_hold.sv | 27 ++
 rtl/manual_drive_seq.sv | 191 +++++++++++++++++++
 tb/tb_manual_drive_seq.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/car_pkg.sv
// Shared car controller encodings: power, drive state, motion.
// Used by the manual and auto drive blocks.
package car_pkg;

  typedef enum logic {
    POFF = 1'b0,
    PON  = 1'b1
  } power_e;

  typedef enum logic [1:0] {
    NSTART = 2'b00,
    START  = 2'b01,
    MOVING = 2'b10
  } drive_e;

  typedef enum logic [3:0] {
    NON_MOVING   = 4'b0000,
    MOVE_FORWARD = 4'b0001,
    MOVE_BACK    = 4'b0010,
    TURN_LEFT    = 4'b0100,
    TURN_RIGHT   = 4'b1000
  } move_e;

  function automatic logic [2:0] state_led(
    input power_e p,
    input drive_e s
  );
    logic [2:0] r;
    r = 3'b000;
    if (p == PON) begin
      unique case (s)
        NSTART:  r = 3'b001;
        START:   r = 3'b010;
        MOVING:  r = 3'b100;
        default: r = 3'b000;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/manual_drive_seq_if.sv
// Driver-control and display bundle of the manual drive sequencer.
// master = control source / display sink, slave = sequencer.
interface manual_drive_if #(
  parameter int MILE_W = 16
);
  logic              power_btn;
  logic              clutch;
  logic              brake;
  logic              throttle;
  logic              rgs;
  logic              left;
  logic              right;
  logic              power;
  logic [1:0]        state;
  logic [3:0]        moving_state;
  logic              turn_left_light;
  logic              turn_right_light;
  logic              power_light;
  logic [2:0]        state_light;
  logic [3:0]        moving_light;
  logic [MILE_W-1:0] mileage;

  modport master (
    output power_btn, clutch, brake, throttle,
    output rgs, left, right,
    input  power, state, moving_state,
    input  turn_left_light, turn_right_light,
    input  power_light, state_light,
    input  moving_light, mileage
  );

  modport slave (
    input  power_btn, clutch, brake, throttle,
    input  rgs, left, right,
    output power, state, moving_state,
    output turn_left_light, turn_right_light,
    output power_light, state_light,
    output moving_light, mileage
  );
endinterface

// File: rtl/manual_drive_seq_btn_hold.sv
// Consecutive-high counter: fires on the HOLD-th armed high cycle.
// Any low or unarmed cycle restarts the count.
module btn_hold #(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic arm,
  output logic fire
);
  localparam int CW = $clog2(HOLD + 1);

  logic [CW-1:0] cnt_q;

  assign fire = arm & btn & (cnt_q == CW'(HOLD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!(arm & btn) || fire) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/manual_drive_seq.sv
// Manual-mode car sequencer: power hold, drive FSM, blinkers,
// odometer. Every output comes straight from a register.
module manual_drive_seq #(
  parameter int PON_HOLD   = 4,
  parameter int POFF_HOLD  = 8,
  parameter int BLINK_HALF = 4,
  parameter int MILE_TICK  = 8,
  parameter int MILE_W     = 16
) (
  input logic          clk,
  input logic          rst,
  manual_drive_if.slave bus
);
  import car_pkg::*;

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int TW = (MILE_TICK > 1) ? $clog2(MILE_TICK) : 1;

  power_e            pwr_q, pwr_d;
  drive_e            st_q, st_d;
  move_e             mv_q, mv_d;
  logic              dir_q, dir_d;
  logic              rel_q;
  logic [1:0]        mask_q, mask_d;
  logic [1:0]        lamp_q, lamp_d;
  logic              phase_q, phase_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [MILE_W-1:0] mile_q, mile_d;
  logic [2:0]        sled_q;
  logic              pon_arm, poff_arm;
  logic              pon_fire, poff_fire;
  logic              fault;

  assign pon_arm  = (pwr_q == POFF);
  assign poff_arm = (pwr_q == PON) & rel_q;

  btn_hold #(.HOLD(PON_HOLD)) u_pon (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.power_btn),
    .arm  (pon_arm),
    .fire (pon_fire)
  );

  btn_hold #(.HOLD(POFF_HOLD)) u_poff (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.power_btn),
    .arm  (poff_arm),
    .fire (poff_fire)
  );

  always_comb begin
    fault = 1'b0;
    if (pwr_q == PON) begin
      unique case (st_q)
        NSTART:  fault = bus.throttle & ~bus.clutch;
        MOVING:  fault = (bus.rgs != dir_q) & ~bus.clutch;
        default: fault = 1'b0;
      endcase
    end
  end

  always_comb begin
    pwr_d = pwr_q;
    st_d  = st_q;
    dir_d = dir_q;
    unique case (1'b1)
      pwr_q == POFF: begin
        st_d = NSTART;
        if (pon_fire) pwr_d = PON;
      end
      poff_fire | fault: begin
        pwr_d = POFF;
        st_d  = NSTART;
        dir_d = 1'b0;
      end
      default: begin
        unique case (st_q)
          NSTART: begin
            if (!bus.brake && bus.throttle &&
                bus.clutch && !bus.rgs)
              st_d = START;
          end
          START: begin
            if (bus.brake) begin
              st_d = NSTART;
            end else if (bus.throttle && !bus.clutch) begin
              st_d  = MOVING;
              dir_d = bus.rgs;
            end
          end
          MOVING: begin
            if (bus.brake)         st_d  = NSTART;
            else if (!bus.throttle) st_d = START;
            else if (bus.clutch)   dir_d = bus.rgs;
          end
          default: st_d = NSTART;
        endcase
      end
    endcase
  end

  // Motion and lamp set follow the next state; phase restarts on change.
  always_comb begin
    mv_d    = NON_MOVING;
    mask_d  = 2'b00;
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
    if (pwr_d == PON && st_d == MOVING) begin
      if (dir_d)                       mv_d = MOVE_BACK;
      else if (bus.left && !bus.right) mv_d = TURN_LEFT;
      else if (bus.right && !bus.left) mv_d = TURN_RIGHT;
      else                             mv_d = MOVE_FORWARD;
    end
    if (pwr_d == PON) begin
      if (st_d == NSTART)         mask_d = 2'b11;
      else if (mv_d != MOVE_BACK) mask_d = {bus.right, bus.left};
    end
    if (mask_d != mask_q) begin
      phase_d = 1'b1;
      bcnt_d  = '0;
    end else if (mask_q != 2'b00) begin
      if (bcnt_q == BW'(BLINK_HALF - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
    lamp_d = mask_d & {2{phase_d}};
  end

  always_comb begin
    tick_d = tick_q;
    mile_d = mile_q;
    if (pwr_q == POFF && pon_fire) begin
      tick_d = '0;
      mile_d = '0;
    end else if (mv_q != NON_MOVING) begin
      if (tick_q == TW'(MILE_TICK - 1)) begin
        tick_d = '0;
        if (mile_q != '1) mile_d = mile_q + 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwr_q   <= POFF;
      st_q    <= NSTART;
      mv_q    <= NON_MOVING;
      dir_q   <= 1'b0;
      rel_q   <= 1'b0;
      mask_q  <= 2'b00;
      lamp_q  <= 2'b00;
      phase_q <= 1'b0;
      bcnt_q  <= '0;
      tick_q  <= '0;
      mile_q  <= '0;
      sled_q  <= 3'b000;
    end else begin
      pwr_q   <= pwr_d;
      st_q    <= st_d;
      mv_q    <= mv_d;
      dir_q   <= dir_d;
      mask_q  <= mask_d;
      lamp_q  <= lamp_d;
      phase_q <= phase_d;
      bcnt_q  <= bcnt_d;
      tick_q  <= tick_d;
      mile_q  <= mile_d;
      sled_q  <= state_led(pwr_d, st_d);
      if (pwr_q == POFF)       rel_q <= 1'b0;
      else if (!bus.power_btn) rel_q <= 1'b1;
    end
  end

  assign bus.power            = pwr_q;
  assign bus.state            = st_q;
  assign bus.moving_state     = mv_q;
  assign bus.turn_left_light  = lamp_q[0];
  assign bus.turn_right_light = lamp_q[1];
  assign bus.power_light      = pwr_q;
  assign bus.state_light      = sled_q;
  assign bus.moving_light     = mv_q;
  assign bus.mileage          = mile_q;
endmodule

// File: tb/tb_manual_drive_seq.sv
// Bench for manual_drive_seq: vector table, directed corners,
// random traffic against a cycle-level behavioural model.
module tb_manual_drive_seq;
  localparam int PON_HOLD   = 4;
  localparam int POFF_HOLD  = 8;
  localparam int BLINK_HALF = 4;
  localparam int MILE_TICK  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pb = 0, clu = 0, brk = 0, thr = 0;
  logic rgs = 0, lft = 0, rgt = 0;

  int checks = 0;
  int errors = 0;

  manual_drive_if #(.MILE_W(16)) bus ();
  manual_drive_if #(.MILE_W(4))  bus4 ();

  assign bus.power_btn  = pb;
  assign bus.clutch     = clu;
  assign bus.brake      = brk;
  assign bus.throttle   = thr;
  assign bus.rgs        = rgs;
  assign bus.left       = lft;
  assign bus.right      = rgt;
  assign bus4.power_btn = pb;
  assign bus4.clutch    = clu;
  assign bus4.brake     = brk;
  assign bus4.throttle  = thr;
  assign bus4.rgs       = rgs;
  assign bus4.left      = lft;
  assign bus4.right     = rgt;

  manual_drive_seq #(
    .PON_HOLD(PON_HOLD), .POFF_HOLD(POFF_HOLD),
    .BLINK_HALF(BLINK_HALF), .MILE_TICK(MILE_TICK),
    .MILE_W(16)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  manual_drive_seq #(
    .PON_HOLD(PON_HOLD), .POFF_HOLD(POFF_HOLD),
    .BLINK_HALF(BLINK_HALF), .MILE_TICK(MILE_TICK),
    .MILE_W(4)
  ) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  always #5 clk = ~clk;

  // Behavioural model: run lengths, ages and totals, not counters.
  int m_pow, m_st, m_dir, m_rel;
  int on_run, off_run;
  int m_mv, m_mask, m_age, m_mc;

  task automatic model_reset();
    m_pow = 0; m_st = 0; m_dir = 0; m_rel = 0;
    on_run = 0; off_run = 0;
    m_mv = 0; m_mask = 0; m_age = 0; m_mc = 0;
  endtask

  task automatic model_step();
    int fault;
    int nmask;
    if (m_mv != 0) m_mc++;
    if (m_pow == 0) begin
      on_run = pb ? on_run + 1 : 0;
      if (on_run == PON_HOLD) begin
        m_pow = 1; m_st = 0; m_mc = 0;
        on_run = 0; off_run = 0; m_rel = 0;
      end
    end else begin
      fault = ((m_st == 0 && thr && !clu) ||
               (m_st == 2 && int'(rgs) != m_dir && !clu)) ? 1 : 0;
      off_run = (pb && m_rel == 1) ? off_run + 1 : 0;
      if (!pb) m_rel = 1;
      if (fault == 1 || off_run == POFF_HOLD) begin
        m_pow = 0; m_st = 0; m_dir = 0;
        m_rel = 0; off_run = 0;
      end else begin
        case (m_st)
          0: if (!brk && thr && clu && !rgs) m_st = 1;
          1: if (brk) m_st = 0;
             else if (thr && !clu) begin
               m_st = 2; m_dir = int'(rgs);
             end
          2: if (brk) m_st = 0;
             else if (!thr) m_st = 1;
             else if (clu) m_dir = int'(rgs);
          default: m_st = 0;
        endcase
      end
    end
    m_mv = 0;
    if (m_pow == 1 && m_st == 2) begin
      if (m_dir == 1)       m_mv = 2;
      else if (lft && !rgt) m_mv = 4;
      else if (rgt && !lft) m_mv = 8;
      else                  m_mv = 1;
    end
    if (m_pow == 0)      nmask = 0;
    else if (m_st == 0)  nmask = 3;
    else if (m_mv == 2)  nmask = 0;
    else                 nmask = int'({rgt, lft});
    if (nmask != m_mask) m_age = 0;
    else                 m_age++;
    m_mask = nmask;
  endtask

  function automatic int exp_lamps();
    return ((m_age / BLINK_HALF) % 2 == 0) ? m_mask : 0;
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all();
    chk("power", 32'(bus.power), m_pow);
    chk("state", 32'(bus.state), m_st);
    chk("moving_state", 32'(bus.moving_state), m_mv);
    chk("lamps",
        32'({bus.turn_right_light, bus.turn_left_light}),
        exp_lamps());
    chk("power_light", 32'(bus.power_light), m_pow);
    chk("state_light", 32'(bus.state_light),
        (m_pow == 1) ? (1 << m_st) : 0);
    chk("moving_light", 32'(bus.moving_light), m_mv);
    chk("mileage", 32'(bus.mileage), sat(m_mc / MILE_TICK, 65535));
    chk("mileage4", 32'(bus4.mileage), sat(m_mc / MILE_TICK, 15));
    chk("power4", 32'(bus4.power), m_pow);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(logic p, logic c, logic b, logic t,
                        logic g, logic l, logic r);
    pb = p; clu = c; brk = b; thr = t;
    rgs = g; lft = l; rgt = r;
  endtask

  typedef struct {
    logic p, c, b, t, g, l, r;
    logic       e_pow;
    logic [1:0] e_st;
    logic [3:0] e_mv;
    logic [1:0] e_lamp;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic [6:0] in, logic e_pow,
                              logic [1:0] e_st, logic [3:0] e_mv,
                              logic [1:0] e_lamp);
    vec_t v;
    {v.p, v.c, v.b, v.t, v.g, v.l, v.r} = in;
    v.e_pow = e_pow; v.e_st = e_st;
    v.e_mv = e_mv; v.e_lamp = e_lamp;
    return v;
  endfunction

  initial begin
    // inputs: pb clu brk thr rgs left right
    tbl[0]  = mk(7'b1000000, 0, 2'd0, 4'b0000, 2'b00);
    tbl[1]  = mk(7'b1000000, 0, 2'd0, 4'b0000, 2'b00);
    tbl[2]  = mk(7'b1000000, 0, 2'd0, 4'b0000, 2'b00);
    tbl[3]  = mk(7'b0000000, 0, 2'd0, 4'b0000, 2'b00);
    tbl[4]  = mk(7'b1000000, 0, 2'd0, 4'b0000, 2'b00);
    tbl[5]  = mk(7'b1000000, 0, 2'd0, 4'b0000, 2'b00);
    tbl[6]  = mk(7'b1000000, 0, 2'd0, 4'b0000, 2'b00);
    tbl[7]  = mk(7'b1000000, 1, 2'd0, 4'b0000, 2'b11);
    tbl[8]  = mk(7'b0101000, 1, 2'd1, 4'b0000, 2'b00);
    tbl[9]  = mk(7'b0001000, 1, 2'd2, 4'b0001, 2'b00);
    tbl[10] = mk(7'b0001010, 1, 2'd2, 4'b0100, 2'b01);
    tbl[11] = mk(7'b0001010, 1, 2'd2, 4'b0100, 2'b01);
    tbl[12] = mk(7'b0001010, 1, 2'd2, 4'b0100, 2'b01);
    tbl[13] = mk(7'b0001010, 1, 2'd2, 4'b0100, 2'b01);
    tbl[14] = mk(7'b0001010, 1, 2'd2, 4'b0100, 2'b00);
    tbl[15] = mk(7'b0001010, 1, 2'd2, 4'b0100, 2'b00);
    tbl[16] = mk(7'b0001010, 1, 2'd2, 4'b0100, 2'b00);
    tbl[17] = mk(7'b0001010, 1, 2'd2, 4'b0100, 2'b00);
    tbl[18] = mk(7'b0001010, 1, 2'd2, 4'b0100, 2'b01);
    tbl[19] = mk(7'b0001100, 0, 2'd0, 4'b0000, 2'b00);

    model_reset();
    @(negedge clk);
    chk("rst power", 32'(bus.power), 0);
    chk("rst state", 32'(bus.state), 0);
    chk("rst moving_state", 32'(bus.moving_state), 0);
    chk("rst lamps",
        32'({bus.turn_right_light, bus.turn_left_light}), 0);
    chk("rst state_light", 32'(bus.state_light), 0);
    chk("rst mileage", 32'(bus.mileage), 0);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      set_in(tbl[i].p, tbl[i].c, tbl[i].b, tbl[i].t,
             tbl[i].g, tbl[i].l, tbl[i].r);
      cycle();
      chk($sformatf("vec%0d power", i),
          32'(bus.power), 32'(tbl[i].e_pow));
      chk($sformatf("vec%0d state", i),
          32'(bus.state), 32'(tbl[i].e_st));
      chk($sformatf("vec%0d moving_state", i),
          32'(bus.moving_state), 32'(tbl[i].e_mv));
      chk($sformatf("vec%0d lamps", i),
          32'({bus.turn_right_light, bus.turn_left_light}),
          32'(tbl[i].e_lamp));
    end

    // Power back on: odometer restarts, then 24 forward cycles.
    set_in(1, 0, 0, 0, 0, 0, 0);
    repeat (4) cycle();
    chk("repower power", 32'(bus.power), 1);
    chk("repower mileage", 32'(bus.mileage), 0);
    set_in(0, 1, 0, 1, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 1, 0, 0, 0);
    cycle();
    chk("fwd moving_state", 32'(bus.moving_state), 32'h1);
    repeat (24) cycle();
    chk("odo 24 cycles", 32'(bus.mileage), 3);

    // Clutched reverse shift, then throttle release and brake.
    set_in(0, 1, 0, 1, 1, 0, 0);
    cycle();
    chk("reverse moving_state", 32'(bus.moving_state), 32'h2);
    chk("reverse lamps",
        32'({bus.turn_right_light, bus.turn_left_light}), 0);
    set_in(0, 1, 0, 0, 1, 0, 0);
    cycle();
    chk("coast state", 32'(bus.state), 1);
    chk("coast mileage", 32'(bus.mileage), 3);
    set_in(0, 0, 1, 0, 0, 0, 0);
    cycle();
    chk("brake state", 32'(bus.state), 0);
    chk("brake lamps",
        32'({bus.turn_right_light, bus.turn_left_light}), 3);
    repeat (5) cycle();

    // Hold-to-off, then keep holding: re-power, no second power-off.
    set_in(1, 0, 0, 0, 0, 0, 0);
    repeat (7) cycle();
    chk("hold7 power", 32'(bus.power), 1);
    cycle();
    chk("hold8 power", 32'(bus.power), 0);
    repeat (4) cycle();
    chk("held repower", 32'(bus.power), 1);
    repeat (20) cycle();
    chk("held 20 power", 32'(bus.power), 1);

    // Asynchronous reset in the middle of NSTART blinking.
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (2) cycle();
    #2 rst = 1'b0;
    #1;
    chk("async lamps",
        32'({bus.turn_right_light, bus.turn_left_light}), 0);
    chk("async power", 32'(bus.power), 0);
    chk("async state_light", 32'(bus.state_light), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Long forward run: narrow odometer saturates.
    set_in(1, 0, 0, 0, 0, 0, 0);
    repeat (4) cycle();
    set_in(0, 1, 0, 1, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 1, 0, 0, 0);
    cycle();
    repeat (130) cycle();
    chk("odo wide", 32'(bus.mileage), 16);
    chk("odo saturate", 32'(bus4.mileage), 15);

    for (int i = 0; i < 3000; i++) begin
      pb  = ((i % 150) < 12) || ($urandom_range(0, 19) == 0);
      clu = ($urandom_range(0, 1) == 1);
      brk = ($urandom_range(0, 9) == 0);
      thr = ($urandom_range(0, 9) < 7);
      rgs = ($urandom_range(0, 4) == 0);
      lft = ($urandom_range(0, 2) == 0);
      rgt = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
